axi_lite_reg_slave: RTL
=======================

# axi_lite_reg_slave

AXI4-Lite slave register bank sitting directly downstream of the `axi_lite_test` master's M00_AXI port, in place of the slave VIP. It gives that master a real target for its write-then-readback burst. The block holds C_NUM_REGS 32-bit registers: all but the last are read/write, and the last is a read-only transaction counter. Register contents are exported to the fabric. Out-of-range and read-only accesses are flagged with SLVERR.

## Interface
- C_ADDR_WIDTH, 6: byte-address width; word index = addr[C_ADDR_WIDTH-1:2]
- C_NUM_REGS, 8: register count; power of two, 2 ≤ C_NUM_REGS ≤ 2^(C_ADDR_WIDTH-2)
- ACLK  in  1  sole clock, rising edge
- ARESET  in  1  reset; synchronous, active-high
- S_AXI_AWADDR  in  C_ADDR_WIDTH  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write-address handshake
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte strobes
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  write-data handshake
- S_AXI_BRESP  out  2  write response
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  write-response handshake
- S_AXI_ARADDR  in  C_ADDR_WIDTH  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read-address handshake
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  read response
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  read-data handshake
- REG_OUT  out  32*C_NUM_REGS  flat copy of all registers; register i is at [32i+31:32i]

## Operation
- Register map:
  - Index 0..C_NUM_REGS-2: RW, byte-strobed.
  - Index C_NUM_REGS-1: RO, value {wr_ok_cnt[15:0], rd_ok_cnt[15:0]}.
  - Index ≥ C_NUM_REGS: unmapped.
- Write FSM states:
  - W_IDLE: AWREADY=WREADY=1. AW and W are captured independently, in any order or in the same cycle. Once a channel is captured, its READY drops.
  - W_IDLE → W_RESP: on the edge where both AW and W are held. At that same edge the write commits and BVALID rises.
  - W_RESP: BVALID=1, held until BREADY. On the B handshake, return to W_IDLE with AWREADY=WREADY=1 in the next cycle.
- Read FSM states:
  - R_IDLE: ARREADY=1.
  - R_IDLE → R_RESP: on the AR handshake edge, RDATA/RRESP are latched from current register state.
  - R_RESP: RVALID=1, ARREADY=0, held until RREADY, then return to R_IDLE.
- Write commit: for each byte b with WSTRB[b]=1, reg[idx][8b+7:8b] ← WDATA[8b+7:8b]. A write with WSTRB=0 is legal: OKAY, no change.
- Errors:
  - Write to the RO index or an unmapped index: BRESP=2'b10, no state change.
  - Read of an unmapped index: RRESP=2'b10, RDATA=0.
  - All other accesses: OKAY (2'b00).
- Counters:
  - wr_ok_cnt increments on each B handshake with OKAY.
  - rd_ok_cnt increments on each R handshake with OKAY.
  - Both are 16-bit and wrap 0xFFFF → 0.
  - A read of the counter register reports the value before its own R handshake.
- Read and write FSMs are fully independent; at most one write and one read outstanding.

## Timing
- Reset (ARESET=1 sampled at an edge):
  - All registers, counters, BVALID and RVALID go to 0; BRESP=RRESP=0; RDATA=0.
  - AWREADY=WREADY=ARREADY=0 while ARESET is high, rising to 1 in the first cycle after deassertion.
- Reset mid-transaction: captured AW/W/AR and any pending response are discarded and no response is issued.
- Write latency: AW and W handshakes in cycle T → BVALID=1 in T+1, and REG_OUT shows the new value in T+1.
- Read latency: AR handshake in cycle T → RVALID=1 with data in T+1.
- Same-edge read/write collision on one register: the read returns the pre-write value.
- Back-to-back throughput: with BREADY and RREADY tied high, one write every 2 cycles and one read every 2 cycles.
- Once asserted, VALID outputs and their payloads are stable until the handshake.

## Structure
- Package axi_lite_reg_pkg holds:
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10
  - typedef enum for the write states {W_IDLE, W_RESP}
  - typedef enum for the read states {R_IDLE, R_RESP}
- Single module with no sub-module. The two FSMs plus the decode logic are small enough that splitting them adds only port plumbing.

## Test plan
- Reset, then AW and W in the same cycle: addr 0x04, data 0xDEADBEEF, strb 0xF → BVALID in the next cycle with OKAY; REG_OUT[63:32]=0xDEADBEEF; a read of 0x04 returns 0xDEADBEEF, OKAY.
- W issued 3 cycles before AW: addr 0x00, data 0x11223344, strb 0x5 on a register holding 0 → register = 0x00220044; BRESP OKAY.
- Write to 0x1C (RO, C_NUM_REGS=8) and read of 0x20 (unmapped, C_ADDR_WIDTH=6) → BRESP=2'b10 with registers unchanged; RRESP=2'b10 with RDATA=0.
- BREADY/RREADY held low for 5 cycles → BVALID/RVALID and payloads stay stable; no new AW/W/AR is accepted until the handshake.
- After 3 OKAY writes and 2 OKAY reads, read 0x1C → 0x00030002; with the counters preset near wrap, 0xFFFF + 1 → 0x0000.
- ARESET asserted while BVALID=1 → BVALID=0 at the next edge; registers read back as 0; no B handshake is counted.

Source files
------------

// File: rtl/axi_lite_reg_pkg.sv
// axi_lite_reg_pkg: response codes and FSM state types shared by the AXI4-Lite register slave
package axi_lite_reg_pkg;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;
endpackage

// File: rtl/axi_lite_reg_slave.sv
// axi_lite_reg_slave: AXI4-Lite register bank with byte-strobed RW registers and a read-only OKAY-transaction counter
module axi_lite_reg_slave
  import axi_lite_reg_pkg::*;
#(
  parameter int C_ADDR_WIDTH = 6,
  parameter int C_NUM_REGS = 8
) (
  input  logic                      ACLK,
  input  logic                      ARESET,
  input  logic [C_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                S_AXI_AWPROT,
  input  logic                      S_AXI_AWVALID,
  output logic                      S_AXI_AWREADY,
  input  logic [31:0]               S_AXI_WDATA,
  input  logic [3:0]                S_AXI_WSTRB,
  input  logic                      S_AXI_WVALID,
  output logic                      S_AXI_WREADY,
  output logic [1:0]                S_AXI_BRESP,
  output logic                      S_AXI_BVALID,
  input  logic                      S_AXI_BREADY,
  input  logic [C_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                S_AXI_ARPROT,
  input  logic                      S_AXI_ARVALID,
  output logic                      S_AXI_ARREADY,
  output logic [31:0]               S_AXI_RDATA,
  output logic [1:0]                S_AXI_RRESP,
  output logic                      S_AXI_RVALID,
  input  logic                      S_AXI_RREADY,
  output logic [32*C_NUM_REGS-1:0]  REG_OUT
);
  localparam int IW = C_ADDR_WIDTH - 2;
  localparam logic [IW-1:0] LAST = IW'(C_NUM_REGS - 1);
  w_state_t w_state;
  r_state_t r_state;
  logic aw_held, w_held, aw_hs, w_hs, aw_full, w_full, wr_ok, rd_ok;
  logic [IW-1:0] aw_idx, widx, ridx;
  logic [31:0] w_data, wd, rword;
  logic [3:0] w_strb, ws;
  logic [31:0] regs [C_NUM_REGS-1];
  logic [31:0] words [C_NUM_REGS];
  logic [15:0] wr_cnt, rd_cnt;
  logic unused;
  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  always_comb begin
    aw_hs = S_AXI_AWREADY && S_AXI_AWVALID;
    w_hs = S_AXI_WREADY && S_AXI_WVALID;
    aw_full = aw_held || aw_hs;
    w_full = w_held || w_hs;
    widx = aw_hs ? S_AXI_AWADDR[C_ADDR_WIDTH-1:2] : aw_idx;
    wd = w_hs ? S_AXI_WDATA : w_data;
    ws = w_hs ? S_AXI_WSTRB : w_strb;
    wr_ok = widx < LAST;
    ridx = S_AXI_ARADDR[C_ADDR_WIDTH-1:2];
    rd_ok = ridx <= LAST;
    for (int i = 0; i < C_NUM_REGS - 1; i++) words[i] = regs[i];
    words[C_NUM_REGS-1] = {wr_cnt, rd_cnt};
    rword = '0;
    for (int i = 0; i < C_NUM_REGS; i++) rword = (ridx == IW'(i)) ? words[i] : rword;
  end
  for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
    assign REG_OUT[32*g +: 32] = words[g];
  end
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state <= W_IDLE;
      aw_held <= 1'b0;
      w_held <= 1'b0;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY <= 1'b0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP <= RESP_OKAY;
      wr_cnt <= '0;
      for (int i = 0; i < C_NUM_REGS - 1; i++) regs[i] <= '0;
    end else if (w_state == W_IDLE) begin
      if (aw_hs) aw_idx <= S_AXI_AWADDR[C_ADDR_WIDTH-1:2];
      if (w_hs) begin
        w_data <= S_AXI_WDATA;
        w_strb <= S_AXI_WSTRB;
      end
      if (aw_full && w_full) begin
        for (int i = 0; i < C_NUM_REGS - 1; i++)
          for (int b = 0; b < 4; b++)
            if (wr_ok && widx == IW'(i) && ws[b]) regs[i][8*b +: 8] <= wd[8*b +: 8];
        S_AXI_BVALID <= 1'b1;
        S_AXI_BRESP <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        w_state <= W_RESP;
        aw_held <= 1'b0;
        w_held <= 1'b0;
        S_AXI_AWREADY <= 1'b0;
        S_AXI_WREADY <= 1'b0;
      end else begin
        aw_held <= aw_full;
        w_held <= w_full;
        S_AXI_AWREADY <= !aw_full;
        S_AXI_WREADY <= !w_full;
      end
    end else if (S_AXI_BREADY) begin
      S_AXI_BVALID <= 1'b0;
      w_state <= W_IDLE;
      S_AXI_AWREADY <= 1'b1;
      S_AXI_WREADY <= 1'b1;
      if (S_AXI_BRESP == RESP_OKAY) wr_cnt <= wr_cnt + 16'd1;
    end
  end
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= R_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RRESP <= RESP_OKAY;
      S_AXI_RDATA <= '0;
      rd_cnt <= '0;
    end else if (r_state == R_IDLE) begin
      if (S_AXI_ARREADY && S_AXI_ARVALID) begin
        S_AXI_RDATA <= rword;
        S_AXI_RRESP <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        S_AXI_RVALID <= 1'b1;
        S_AXI_ARREADY <= 1'b0;
        r_state <= R_RESP;
      end else begin
        S_AXI_ARREADY <= 1'b1;
      end
    end else if (S_AXI_RREADY) begin
      S_AXI_RVALID <= 1'b0;
      S_AXI_ARREADY <= 1'b1;
      r_state <= R_IDLE;
      if (S_AXI_RRESP == RESP_OKAY) rd_cnt <= rd_cnt + 16'd1;
    end
  end
endmodule
